// File: rtl/ipv4_arp_lut_arbiter_pkg.sv
// Shared definitions for the ARP lookup arbiter: FSM encoding, MAC width, saturating counter helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package ipv4_arp_lut_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam int MAC_WIDTH_DEF = 48;
    localparam int SAT_W         = 64;

    // Callers zero-extend their counter and pass its own all-ones value as the ceiling.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val >= max_val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/ipv4_arp_lut_arbiter_rr_arbiter.sv
// Round-robin picker: first active request at or after ptr, one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the grant is used.
module ipv4_arp_lut_arbiter_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [REQ_BITS-1:0] gnt_idx,
    output logic                gnt_any
);

    int pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!gnt_any && req[pos]) begin
                gnt_any  = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = REQ_BITS'(pos);
            end
        end
    end

endmodule

// File: rtl/ipv4_arp_lut_arbiter.sv
// Shares the ARP table lookup port among NUM_REQ requesters, one lookup in flight, round-robin.
// Latency: accept T, issue T+1, response one cycle after the table result (T+4 with a 2-stage table).
// Backpressure: requesters wait for o_req_ready; responses cannot be stalled; stale results are drained in IDLE.
module ipv4_arp_lut_arbiter
    import ipv4_arp_lut_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REQ_BITS       = 2,
    parameter int MAC_WIDTH      = MAC_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [32*NUM_REQ-1:0]   i_req_daddr,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [NUM_REQ-1:0]      o_rsp_valid,
    output logic                    o_rsp_found,
    output logic                    o_rsp_timeout,
    output logic [MAC_WIDTH-1:0]    o_rsp_eth_addr,
    output logic                    o_lut_daddr_valid,
    output logic [31:0]             o_lut_daddr,
    output logic                    o_lut_rd,
    input  logic                    i_lut_valid,
    input  logic                    i_lut_found,
    input  logic [MAC_WIDTH-1:0]    i_lut_eth_addr,
    output logic [CNT_WIDTH-1:0]    o_hit_cnt,
    output logic [CNT_WIDTH-1:0]    o_miss_cnt,
    output logic [CNT_WIDTH-1:0]    o_timeout_cnt,
    output logic [CNT_WIDTH-1:0]    o_stale_cnt
);

    localparam int WC_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WC_W-1:0]     WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SAT_W-1:0]    CNT_MAX   = SAT_W'({CNT_WIDTH{1'b1}});
    localparam logic [REQ_BITS-1:0] LAST_REQ  = REQ_BITS'(NUM_REQ - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [REQ_BITS-1:0]    rr_ptr;
    logic [REQ_BITS-1:0]    cur_idx;
    logic [31:0]            cur_daddr;
    logic [WC_W-1:0]        wait_cnt;
    logic                   rsp_found;
    logic                   rsp_timeout;
    logic [MAC_WIDTH-1:0]   rsp_mac;
    logic [CNT_WIDTH-1:0]   hit_cnt;
    logic [CNT_WIDTH-1:0]   miss_cnt;
    logic [CNT_WIDTH-1:0]   timeout_cnt;
    logic [CNT_WIDTH-1:0]   stale_cnt;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [REQ_BITS-1:0]    arb_idx;
    logic                   arb_any;

    logic                   drain;
    logic                   grant;
    logic                   lut_hit;
    logic                   lut_expire;

    ipv4_arp_lut_arbiter_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_rr_arbiter (
        .req     (i_req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // A result seen in IDLE belongs to an abandoned lookup and wins over new grants.
    always_comb begin
        drain      = (state == ST_IDLE) && i_lut_valid;
        grant      = (state == ST_IDLE) && !i_lut_valid && arb_any;
        lut_hit    = (state == ST_WAIT) && i_lut_valid;
        lut_expire = (state == ST_WAIT) && !i_lut_valid && (wait_cnt == WAIT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (lut_hit || lut_expire) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // IDLE strobes depend on live inputs, so they are masked while reset is held.
    always_comb begin
        o_req_ready       = (grant && !reset) ? arb_gnt : '0;
        o_lut_rd          = (drain || lut_hit) && !reset;
        o_lut_daddr_valid = (state == ST_ISSUE);
        o_rsp_valid       = (state == ST_RESP) ? (NUM_REQ'(1) << cur_idx) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            cur_idx     <= '0;
            cur_daddr   <= '0;
            wait_cnt    <= '0;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_mac     <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            timeout_cnt <= '0;
            stale_cnt   <= '0;
        end else begin
            if (grant) begin
                cur_idx   <= arb_idx;
                cur_daddr <= i_req_daddr[32*arb_idx +: 32];
                rr_ptr    <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (lut_hit) begin
                rsp_found   <= i_lut_found;
                rsp_mac     <= i_lut_found ? i_lut_eth_addr : '0;
                rsp_timeout <= 1'b0;
            end else if (lut_expire) begin
                rsp_found   <= 1'b0;
                rsp_mac     <= '0;
                rsp_timeout <= 1'b1;
            end

            if (drain) begin
                stale_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(stale_cnt), CNT_MAX));
            end

            if (state == ST_RESP) begin
                if (rsp_timeout) begin
                    timeout_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(timeout_cnt), CNT_MAX));
                end else if (rsp_found) begin
                    hit_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(hit_cnt), CNT_MAX));
                end else begin
                    miss_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(miss_cnt), CNT_MAX));
                end
            end
        end
    end

    assign o_lut_daddr    = cur_daddr;
    assign o_rsp_found    = rsp_found;
    assign o_rsp_timeout  = rsp_timeout;
    assign o_rsp_eth_addr = rsp_mac;
    assign o_hit_cnt      = hit_cnt;
    assign o_miss_cnt     = miss_cnt;
    assign o_timeout_cnt  = timeout_cnt;
    assign o_stale_cnt    = stale_cnt;

endmodule

// File: tb/tb_ipv4_arp_lut_arbiter.sv
// Directed bench for ipv4_arp_lut_arbiter: table of single lookups plus hand-written multi-cycle sequences.
// Counters are built 4 bits wide so saturation at 15 is reachable.
module tb_ipv4_arp_lut_arbiter;

    localparam int NR  = 4;
    localparam int MW  = 48;
    localparam int TO  = 16;
    localparam int CW  = 4;
    localparam int CMX = 15;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    i_req_valid;
    logic [32*NR-1:0] i_req_daddr;
    logic [NR-1:0]    o_req_ready;
    logic [NR-1:0]    o_rsp_valid;
    logic             o_rsp_found;
    logic             o_rsp_timeout;
    logic [MW-1:0]    o_rsp_eth_addr;
    logic             o_lut_daddr_valid;
    logic [31:0]      o_lut_daddr;
    logic             o_lut_rd;
    logic             i_lut_valid;
    logic             i_lut_found;
    logic [MW-1:0]    i_lut_eth_addr;
    logic [CW-1:0]    o_hit_cnt;
    logic [CW-1:0]    o_miss_cnt;
    logic [CW-1:0]    o_timeout_cnt;
    logic [CW-1:0]    o_stale_cnt;

    ipv4_arp_lut_arbiter #(
        .NUM_REQ        (NR),
        .REQ_BITS       (2),
        .MAC_WIDTH      (MW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_req_valid       (i_req_valid),
        .i_req_daddr       (i_req_daddr),
        .o_req_ready       (o_req_ready),
        .o_rsp_valid       (o_rsp_valid),
        .o_rsp_found       (o_rsp_found),
        .o_rsp_timeout     (o_rsp_timeout),
        .o_rsp_eth_addr    (o_rsp_eth_addr),
        .o_lut_daddr_valid (o_lut_daddr_valid),
        .o_lut_daddr       (o_lut_daddr),
        .o_lut_rd          (o_lut_rd),
        .i_lut_valid       (i_lut_valid),
        .i_lut_found       (i_lut_found),
        .i_lut_eth_addr    (i_lut_eth_addr),
        .o_hit_cnt         (o_hit_cnt),
        .o_miss_cnt        (o_miss_cnt),
        .o_timeout_cnt     (o_timeout_cnt),
        .o_stale_cnt       (o_stale_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          r;
        logic [31:0] daddr;
        int          dly;
        logic        to;
        logic        fnd;
        logic [47:0] mac;
        logic        exp_found;
        logic [47:0] exp_mac;
        logic        exp_to;
    } vec_t;

    vec_t vecs[5];

    int errors;
    int checks;
    int m_hit, m_miss, m_to, m_stale;
    int wc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMX) ? CMX : v + 1;
    endfunction

    task automatic chk_cnts(input string tag);
        chk({tag, "_hit_cnt"},     64'(o_hit_cnt),     64'(m_hit));
        chk({tag, "_miss_cnt"},    64'(o_miss_cnt),    64'(m_miss));
        chk({tag, "_timeout_cnt"}, 64'(o_timeout_cnt), 64'(m_to));
        chk({tag, "_stale_cnt"},   64'(o_stale_cnt),   64'(m_stale));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},   64'(o_req_ready),       64'd0);
        chk({tag, "_rsp_valid"},   64'(o_rsp_valid),       64'd0);
        chk({tag, "_rsp_found"},   64'(o_rsp_found),       64'd0);
        chk({tag, "_rsp_timeout"}, 64'(o_rsp_timeout),     64'd0);
        chk({tag, "_rsp_mac"},     64'(o_rsp_eth_addr),    64'd0);
        chk({tag, "_lut_vld"},     64'(o_lut_daddr_valid), 64'd0);
        chk({tag, "_lut_daddr"},   64'(o_lut_daddr),       64'd0);
        chk({tag, "_lut_rd"},      64'(o_lut_rd),          64'd0);
        m_hit = 0; m_miss = 0; m_to = 0; m_stale = 0;
        chk_cnts(tag);
    endtask

    // Called just after a posedge; returns just after the posedge that re-enters IDLE.
    task automatic lookup(input string tag, input int r, input logic [31:0] da, input int dly,
                          input logic to, input logic fnd, input logic [47:0] mac,
                          input logic exp_found, input logic [47:0] exp_mac, input logic exp_to,
                          input logic hold, output int wait_cyc);
        int early;
        logic [NR-1:0] exp_gnt;
        exp_gnt = '0;
        exp_gnt[r] = 1'b1;
        early = 0;
        wait_cyc = 0;
        i_req_valid[r] = 1'b1;
        i_req_daddr[32*r +: 32] = da;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_req_ready != '0) break;
            wait_cyc++;
            @(posedge clk); #1;
        end
        chk({tag, "_grant"}, 64'(o_req_ready), 64'(exp_gnt));
        @(posedge clk); #1;
        if (!hold) i_req_valid[r] = 1'b0;
        @(negedge clk);
        chk({tag, "_issue_vld"},  64'(o_lut_daddr_valid), 64'd1);
        chk({tag, "_issue_addr"}, 64'(o_lut_daddr),       64'(da));
        if (to) begin
            for (int k = 0; k < TO; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (o_rsp_valid != '0 || o_lut_daddr_valid) early++;
            end
        end else begin
            for (int k = 0; k < dly; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (o_rsp_valid != '0 || o_lut_rd) early++;
            end
            @(posedge clk); #1;
            i_lut_valid    = 1'b1;
            i_lut_found    = fnd;
            i_lut_eth_addr = mac;
            @(negedge clk);
            chk({tag, "_lut_rd"}, 64'(o_lut_rd), 64'd1);
        end
        chk({tag, "_wait_quiet"}, 64'(early), 64'd0);
        @(posedge clk); #1;
        i_lut_valid    = 1'b0;
        i_lut_eth_addr = 48'hBAD0BAD0BAD0;
        @(negedge clk);
        chk({tag, "_rsp_valid"},   64'(o_rsp_valid),    64'(exp_gnt));
        chk({tag, "_rsp_found"},   64'(o_rsp_found),    64'(exp_found));
        chk({tag, "_rsp_mac"},     64'(o_rsp_eth_addr), 64'(exp_mac));
        chk({tag, "_rsp_timeout"}, 64'(o_rsp_timeout),  64'(exp_to));
        if (exp_to)         m_to   = sat(m_to);
        else if (exp_found) m_hit  = sat(m_hit);
        else                m_miss = sat(m_miss);
        @(posedge clk); #1;
        chk_cnts(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        m_hit = 0; m_miss = 0; m_to = 0; m_stale = 0;
        reset = 1'b1;
        i_req_valid = '0;
        i_req_daddr = '0;
        i_lut_valid = 1'b0;
        i_lut_found = 1'b0;
        i_lut_eth_addr = '0;

        //               r  daddr          dly to fnd mac               exp_f exp_mac          exp_to
        vecs[0] = '{0, 32'h0A000001, 1,  0, 1, 48'h001122334455, 1, 48'h001122334455, 0};
        vecs[1] = '{2, 32'hC0A80102, 1,  0, 0, 48'hDEADBEEFCAFE, 0, 48'h000000000000, 0};
        vecs[2] = '{1, 32'h0A0A0A0A, 0,  0, 1, 48'h02AABBCCDDEE, 1, 48'h02AABBCCDDEE, 0};
        vecs[3] = '{3, 32'hAC100005, 15, 0, 1, 48'h0A0B0C0D0E0F, 1, 48'h0A0B0C0D0E0F, 0};
        vecs[4] = '{3, 32'h01020304, 4,  0, 0, 48'hFFFFFFFFFFFF, 0, 48'h000000000000, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("init");
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            lookup($sformatf("vec%0d", v), vecs[v].r, vecs[v].daddr, vecs[v].dly, vecs[v].to,
                   vecs[v].fnd, vecs[v].mac, vecs[v].exp_found, vecs[v].exp_mac,
                   vecs[v].exp_to, 1'b0, wc);
            chk($sformatf("vec%0d_wait", v), 64'(wc), 64'd0);
        end

        // Timeout, then the late result is drained while req1 waits one cycle.
        lookup("tmo", 0, 32'h08080808, 0, 1'b1, 1'b0, 48'h0, 1'b0, 48'h0, 1'b1, 1'b0, wc);
        i_req_valid[1] = 1'b1;
        i_req_daddr[63:32] = 32'h0A000002;
        i_lut_valid    = 1'b1;
        i_lut_found    = 1'b1;
        i_lut_eth_addr = 48'h123456789ABC;
        @(negedge clk);
        chk("stale_rd", 64'(o_lut_rd), 64'd1);
        chk("stale_no_grant", 64'(o_req_ready), 64'd0);
        @(posedge clk); #1;
        i_lut_valid = 1'b0;
        m_stale = sat(m_stale);
        chk("stale_cnt", 64'(o_stale_cnt), 64'(m_stale));
        lookup("post_stale", 1, 32'h0A000002, 1, 1'b0, 1'b1, 48'h00AA00BB00CC,
               1'b1, 48'h00AA00BB00CC, 1'b0, 1'b0, wc);
        chk("post_stale_wait", 64'(wc), 64'd0);

        // Reset in the middle of WAIT: no response, later result treated as stale.
        i_req_valid[2] = 1'b1;
        i_req_daddr[95:64] = 32'hC0A80002;
        @(negedge clk);
        chk("rw_grant", 64'(o_req_ready), 64'b0100);
        @(posedge clk); #1;
        i_req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        reset = 1'b1;
        i_req_valid = 4'hF;
        i_lut_valid = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_hold_rsp", 64'(o_rsp_valid), 64'd0);
        chk("rst_hold_ready", 64'(o_req_ready), 64'd0);
        i_req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_late_rd", 64'(o_lut_rd), 64'd1);
        chk("rst_late_rsp", 64'(o_rsp_valid), 64'd0);
        @(posedge clk); #1;
        i_lut_valid = 1'b0;
        m_stale = sat(m_stale);
        chk_cnts("rst_late");

        // All four held: grant order 0,1,2,3,0 from a freshly reset pointer.
        for (int r = 0; r < NR; r++) begin
            i_req_daddr[32*r +: 32] = 32'hC0000000 + 32'(r);
        end
        i_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            lookup($sformatf("rr%0d", k), k % NR, 32'hC0000000 + 32'(k % NR), 1, 1'b0, 1'b1,
                   48'h0000000000A0 + 48'(k), 1'b1, 48'h0000000000A0 + 48'(k), 1'b0, 1'b1, wc);
            chk($sformatf("rr%0d_wait", k), 64'(wc), 64'd0);
        end
        i_req_valid = '0;

        // Saturation: 17 hits on a 4-bit counter.
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            lookup($sformatf("sat%0d", k), 0, 32'h0A000001, 1, 1'b0, 1'b1, 48'h001122334455,
                   1'b1, 48'h001122334455, 1'b0, 1'b0, wc);
        end
        chk("sat_final", 64'(o_hit_cnt), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ipv4_arp_lut_arbiter.md
Name: ipv4_arp_lut_arbiter

Overview:
Shares the single lookup port of the IPv4 ARP table among NUM_REQ datapath requesters, for example per-port output lookup engines and the ARP-miss handler.
- Arbitrates round-robin and issues one lookup at a time.
- Pops the table's result FIFO and returns found plus MAC to the granted requester.
- Recovers from lost results with a timeout and drains late results.
- Sits between the requesters and the ARP table lookup interface, in the clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_BITS, 2, log2(NUM_REQ)
MAC_WIDTH, 48, Ethernet address width
TIMEOUT_CYCLES, 16, cycles to wait in WAIT before declaring a miss (at least 4)
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-requester lookup request
i_req_daddr  in  32*NUM_REQ  next-hop IPv4 address; requester r uses bits [32r+31:32r]
o_req_ready  out  NUM_REQ  one-hot accept strobe
o_rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle
o_rsp_found  out  1  MAC found, qualified by o_rsp_valid
o_rsp_timeout  out  1  response generated by timeout
o_rsp_eth_addr  out  MAC_WIDTH  resolved MAC; 0 if not found
o_lut_daddr_valid  out  1  lookup strobe to table
o_lut_daddr  out  32  address to table
o_lut_rd  out  1  pop table result FIFO
i_lut_valid  in  1  table result FIFO non-empty
i_lut_found  in  1  result found flag (FIFO head)
i_lut_eth_addr  in  MAC_WIDTH  result MAC (FIFO head)
o_hit_cnt  out  CNT_WIDTH  lookups found
o_miss_cnt  out  CNT_WIDTH  lookups not found; excludes timeouts
o_timeout_cnt  out  CNT_WIDTH  lookups timed out
o_stale_cnt  out  CNT_WIDTH  late results discarded

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-WAIT abandons the lookup with no response. Any later FIFO result is drained as stale.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE, drain case: if i_lut_valid=1, assert o_lut_rd for 1 cycle and increment o_stale_cnt. Make no grant this cycle; drain has priority.
- IDLE, grant case: else if any i_req_valid, grant g = first requester at or after the rr pointer.
  - Assert o_req_ready[g] for 1 cycle and latch i_req_daddr[g] and g.
  - Set rr pointer = g+1 mod NUM_REQ, then go to ISSUE.
- ISSUE: o_lut_daddr_valid=1 for exactly 1 cycle with o_lut_daddr = latched address. Clear the wait counter and go to WAIT.
- o_lut_daddr holds its value outside ISSUE; it is only qualified by o_lut_daddr_valid.
- WAIT, result case: counter increments each cycle. If i_lut_valid=1:
  - assert o_lut_rd the same cycle (fall-through FIFO);
  - capture found and MAC, forcing MAC to 0 when found=0;
  - go to RESP.
- WAIT, timeout case: else if counter == TIMEOUT_CYCLES-1, capture found=0, MAC=0, timeout=1, and go to RESP.
- RESP: o_rsp_valid[g]=1 for 1 cycle with o_rsp_found, o_rsp_eth_addr and o_rsp_timeout valid. Increment exactly one of hit/miss/timeout. Go to IDLE.
- Response data outputs hold their last value; they are qualified by o_rsp_valid only. Requesters cannot backpressure.
- Latency: accept cycle T, issue T+1, response one cycle after i_lut_valid is seen, at the earliest T+4 with the table's 2-stage result path.
- A requester holds i_req_valid and daddr until o_req_ready; it may re-request in the cycle after o_rsp_valid.
- Throughput: one lookup in flight maximum.
- Counters saturate at all-ones and never wrap.
- A result arriving in the same cycle as the timeout threshold is taken as a result, not a timeout.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - MAC_WIDTH default;
  - a saturating-increment function shared with other stats blocks.
- Sub-module rr_arbiter (NUM_REQ, REQ_BITS) is the natural split. It is combinational: request vector and pointer in, one-hot grant and index out. The pointer register stays in the parent.

Test Plan:
- Single hit: req0 daddr 10.0.0.1; table returns found=1, MAC 00:11:22:33:44:55 -> o_rsp_valid=0001, found=1, that MAC, hit_cnt=1.
- Round-robin: all four requesters assert simultaneously and hold -> grant order 0,1,2,3,0; one o_lut_daddr_valid pulse per grant, each with the correct address.
- Miss: table returns found=0 with MAC garbage -> found=0, eth_addr=0, miss_cnt=1.
- Timeout then stale: i_lut_valid withheld 16 cycles -> RESP with timeout=1, found=0, timeout_cnt=1. Result then arrives in IDLE while req1 pending -> o_lut_rd pulse, stale_cnt=1, and req1 is granted the following cycle.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, no o_rsp_valid. A late result after release is drained with stale_cnt=1.
- Saturation with CNT_WIDTH=4: 17 hits -> hit_cnt stays 15.
